axi_lite_traffic_gen: RTL and testbench

//  Native-RTL, parametrised AXI-Lite master traffic generator.

---
 rtl/axi_lite_tg_pkg.sv | 35 +++
 rtl/axi_lite_tg_watchdog.sv | 28 ++
 rtl/axi_lite_traffic_gen.sv | 205 ++++++++++++++++++++
 tb/tb_axi_lite_traffic_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_tg_pkg.sv
// Shared types, status bit positions, AXI response codes and the data pattern
// used by the AXI-Lite traffic generator.
package axi_lite_tg_pkg;

  typedef enum logic [1:0] {
    TG_WR_ONLY = 2'd0,
    TG_RD_ONLY = 2'd1,
    TG_WR_RD   = 2'd2
  } tg_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } tg_state_e;

  localparam int unsigned STATUS_PASS     = 0;
  localparam int unsigned STATUS_TIMEOUT  = 1;
  localparam int unsigned STATUS_RESP_ERR = 2;
  localparam int unsigned STATUS_MISMATCH = 3;
  localparam int unsigned STATUS_ERR_LSB  = 16;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic [63:0] tg_pattern(input logic [63:0] seed, input logic [15:0] idx);
    return seed ^ {48'd0, idx};
  endfunction

endpackage

// File: rtl/axi_lite_tg_watchdog.sv
// Per-wait cycle counter: expires after TIMEOUT enabled cycles without a clear.
// TIMEOUT of zero disables expiry entirely.
module axi_lite_tg_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

  // Fires on the cycle whose edge would make the count reach TIMEOUT.
  assign expired = (TIMEOUT != 0) && en && !clr && (count >= 32'(TIMEOUT - 1));

endmodule

// File: rtl/axi_lite_traffic_gen.sv
// AXI-Lite master traffic generator: NUM_TRANS single-beat writes and/or reads
// with readback compare, error counting and a per-wait watchdog.
module axi_lite_traffic_gen
  import axi_lite_tg_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_TRANS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           ADDR_STRIDE = 4,
  parameter tg_mode_e              MODE        = TG_WR_RD,
  parameter logic [DATA_WIDTH-1:0] DATA_SEED   = 'hA5A5_0000,
  parameter int unsigned           TIMEOUT     = 1024
) (
  input  logic                    clk,
  input  logic                    aresetn,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             status
);

  tg_state_e             state;
  logic [15:0]           idx;
  logic [15:0]           err_cnt;
  logic [15:0]           err_inc;
  logic                  timeout_flag;
  logic                  resp_err_flag;
  logic                  mismatch_flag;
  logic [63:0]           pattern;
  logic [DATA_WIDTH-1:0] data_cur;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic                  last_idx;
  logic                  handshake;
  logic                  wd_en;
  logic                  wd_expired;

  assign pattern  = tg_pattern(64'(DATA_SEED), idx);
  assign data_cur = pattern[DATA_WIDTH-1:0];
  assign addr_cur = BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
  assign last_idx = (idx == 16'(NUM_TRANS - 1));
  assign err_inc  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;

  assign awaddr = addr_cur;
  assign araddr = addr_cur;
  assign wdata  = data_cur;
  assign wstrb  = '1;
  assign awprot = '0;
  assign arprot = '0;

  assign handshake = (awvalid && awready) || (wvalid && wready) || (bvalid && bready) ||
                     (arvalid && arready) || (rvalid && rready);
  assign wd_en     = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                     (state == ST_RD_REQ) || (state == ST_RD_RESP);

  // Every transition between active states happens on a handshake, so clearing
  // on handshake or inactivity also covers clearing on state entry.
  axi_lite_tg_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (handshake || !wd_en),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      awvalid       <= 1'b0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      idx           <= '0;
      err_cnt       <= '0;
      timeout_flag  <= 1'b0;
      resp_err_flag <= 1'b0;
      mismatch_flag <= 1'b0;
    end else if (wd_expired) begin
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      timeout_flag <= 1'b1;
      err_cnt      <= err_inc;
      busy         <= 1'b0;
      done         <= 1'b1;
      state        <= ST_DONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy          <= 1'b1;
            done          <= 1'b0;
            idx           <= '0;
            err_cnt       <= '0;
            timeout_flag  <= 1'b0;
            resp_err_flag <= 1'b0;
            mismatch_flag <= 1'b0;
            if (MODE == TG_RD_ONLY) begin
              arvalid <= 1'b1;
              state   <= ST_RD_REQ;
            end else begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != AXI_RESP_OKAY) begin
              resp_err_flag <= 1'b1;
              err_cnt       <= err_inc;
            end
            if (!last_idx) begin
              idx     <= idx + 16'd1;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= ST_WR_REQ;
            end else if (MODE == TG_WR_RD) begin
              idx     <= '0;
              arvalid <= 1'b1;
              state   <= ST_RD_REQ;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp != AXI_RESP_OKAY) begin
              resp_err_flag <= 1'b1;
              err_cnt       <= err_inc;
            end else if ((MODE == TG_WR_RD) && (rdata != data_cur)) begin
              mismatch_flag <= 1'b1;
              err_cnt       <= err_inc;
            end
            if (last_idx) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx     <= idx + 16'd1;
              arvalid <= 1'b1;
              state   <= ST_RD_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status                  = '0;
    status[STATUS_PASS]     = done && !timeout_flag && (err_cnt == 16'd0);
    status[STATUS_TIMEOUT]  = timeout_flag;
    status[STATUS_RESP_ERR] = resp_err_flag;
    status[STATUS_MISMATCH] = mismatch_flag;
    status[31:16]           = err_cnt;
  end

endmodule

// File: tb/tb_axi_lite_traffic_gen.sv
// Bench for axi_lite_traffic_gen: reactive memory slave with fault injection,
// transaction-level expectations and end-of-run status prediction.
module tb_axi_lite_traffic_gen;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] awaddr, wdata, araddr, status;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready, busy, done;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_lite_traffic_gen #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .NUM_TRANS   (4),
    .BASE_ADDR   (32'h100),
    .ADDR_STRIDE (4),
    .MODE        (axi_lite_tg_pkg::TG_WR_RD),
    .DATA_SEED   (32'hA5A5_0000),
    .TIMEOUT     (16)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .start(start), .busy(busy), .done(done), .status(status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave configuration (-1 = no injection)
  int aw_d, w_d, cor_idx, slverr_w, decerr_r;
  bit nob;

  // Slave state and transaction log
  int cyc = 0, aw_n, w_n, b_n, ar_n, r_n, aw_cnt, w_cnt, w_cyc, done_cyc;
  logic have_aw, have_w, p_aw, p_w, p_b, p_ar, p_r, pv_aw, pv_w, pv_ar, rst_seen, prev_done;
  logic [31:0] p_awaddr, p_wdata, p_araddr, pend_addr, w_val;
  logic [31:0] aw_log [4];
  logic [31:0] mem [logic [31:0]];

  task automatic bus_clear();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    have_aw = 0; have_w = 0; aw_cnt = 0; w_cnt = 0;
    p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
  endtask

  task automatic configure(input int a, input int w, input int c, input int se, input int de, input bit nb);
    aw_d = a; w_d = w; cor_idx = c; slverr_w = se; decerr_r = de; nob = nb;
    bus_clear();
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; w_cyc = 0; done_cyc = 0;
    mem.delete();
    for (int i = 0; i < 4; i++) aw_log[i] = '0;
  endtask

  always @(posedge clk) rst_seen = !aresetn;

  // Outputs are stable between the edges, so a handshake seen at one negedge is
  // exactly the one that occurs at the following posedge.
  always @(negedge clk) begin
    cyc++;
    if (rst_seen) begin
      bus_clear();
    end else begin
      if (pv_aw && !p_aw) begin
        chk("aw_hold", awvalid, 1);
        chk("aw_addr_stable", awaddr, p_awaddr);
      end
      if (pv_w && !p_w) chk("w_hold", wvalid, 1);
      if (pv_ar && !p_ar) chk("ar_hold", arvalid, 1);
      if (p_aw) begin
        chk("aw_one_outstanding", aw_n, b_n);
        chk("aw_addr", p_awaddr, 32'h100 + 4 * aw_n);
        if (aw_n < 4) aw_log[aw_n] = p_awaddr;
        aw_n++; have_aw = 1; aw_cnt = 0; pend_addr = p_awaddr;
      end
      if (p_w) begin
        chk("w_one_outstanding", w_n, b_n);
        chk("w_data", p_wdata, 32'hA5A5_0000 ^ w_n);
        w_n++; have_w = 1; w_cnt = 0; w_val = p_wdata; w_cyc = cyc;
      end
      if (p_b) begin
        bvalid = 0; b_n++;
      end
      if (p_r) begin
        rvalid = 0; r_n++;
      end
      if (p_ar) begin
        chk("ar_one_outstanding", ar_n, r_n);
        chk("ar_addr", p_araddr, 32'h100 + 4 * ar_n);
        rdata = mem.exists(p_araddr) ? mem[p_araddr] : 32'h0;
        if (ar_n == cor_idx) rdata = rdata ^ 32'h0000_00FF;
        rresp = (ar_n == decerr_r) ? 2'b11 : 2'b00;
        rvalid = 1; ar_n++;
      end
      if (have_aw && have_w && !bvalid && !nob) begin
        mem[pend_addr] = w_val;
        bresp = (b_n == slverr_w) ? 2'b10 : 2'b00;
        bvalid = 1; have_aw = 0; have_w = 0;
      end
      if (awvalid && !have_aw) begin
        if (aw_cnt >= aw_d) awready = 1;
        else begin awready = 0; aw_cnt++; end
      end else awready = 0;
      if (wvalid && !have_w) begin
        if (w_cnt >= w_d) wready = 1;
        else begin wready = 0; w_cnt++; end
      end else wready = 0;
      arready = arvalid;
      p_aw = awvalid && awready; p_awaddr = awaddr; pv_aw = awvalid;
      p_w  = wvalid && wready;   p_wdata  = wdata;  pv_w  = wvalid;
      p_ar = arvalid && arready; p_araddr = araddr; pv_ar = arvalid;
      p_b  = bvalid && bready;
      p_r  = rvalid && rready;
    end
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
  end

  // Status predicted from the injected faults of a 4-transaction write+readback run.
  function automatic logic [31:0] model_status(input int c, input int se, input int de, input bit to);
    int err = 0;
    bit re = 0, mm = 0;
    if (to) return {16'd1, 12'd0, 4'b0010};
    for (int i = 0; i < 4; i++) if (i == se) begin err++; re = 1; end
    for (int i = 0; i < 4; i++) begin
      if (i == de) begin err++; re = 1; end
      else if (i == c) begin err++; mm = 1; end
    end
    return {16'(err), 12'd0, mm, re, 1'b0, (err == 0)};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic run(input string tag);
    bit ok = 0;
    pulse_start();
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_done_cleared"}, done, 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk({tag, "_run_completed"}, ok, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input int nw, input int nr);
    chk({tag, "_aw_count"}, aw_n, nw);
    chk({tag, "_w_count"}, w_n, nw);
    chk({tag, "_ar_count"}, ar_n, nr);
    chk({tag, "_r_count"}, r_n, nr);
  endtask

  initial begin
    configure(0, 0, -1, -1, -1, 0);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_status", status, 0);
    chk("reset_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 0);
    aresetn = 1;
    @(negedge clk);

    // 1: clean write+readback
    configure(0, 0, -1, -1, -1, 0);
    run("t1");
    chk("t1_status", status, model_status(-1, -1, -1, 0));
    chk("t1_status_lit", status, 32'h0000_0001);
    chk("t1_first_addr", aw_log[0], 32'h100);
    chk("t1_last_addr", aw_log[3], 32'h10C);
    chk("t1_last_data", mem[32'h10C], 32'hA5A5_0003);
    chk("t1_done_sticky", done, 1);
    check_counts("t1", 4, 4);

    // 2: differing AW/W ready delays
    configure(5, 2, -1, -1, -1, 0);
    run("t2");
    chk("t2_status", status, model_status(-1, -1, -1, 0));
    check_counts("t2", 4, 4);

    // 3: corrupted read data on read 2
    configure(0, 0, 2, -1, -1, 0);
    run("t3");
    chk("t3_status", status, model_status(2, -1, -1, 0));
    chk("t3_status_lit", status, 32'h0001_0008);
    check_counts("t3", 4, 4);

    // 4: SLVERR on write 1, DECERR on read 3
    configure(0, 0, -1, 1, 3, 0);
    run("t4");
    chk("t4_status", status, model_status(-1, 1, 3, 0));
    chk("t4_status_lit", status, 32'h0002_0004);
    check_counts("t4", 4, 4);

    // 5: slave never responds on B
    configure(0, 0, -1, -1, -1, 1);
    run("t5");
    chk("t5_status", status, model_status(-1, -1, -1, 1));
    chk("t5_status_lit", status, 32'h0001_0002);
    chk("t5_timeout_latency", done_cyc - w_cyc, 16);
    chk("t5_all_low", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 0);
    check_counts("t5", 1, 0);

    // 6: reset in WR_REQ, then a run with a start pulse while busy
    configure(5, 0, -1, -1, -1, 0);
    pulse_start();
    repeat (2) @(negedge clk);
    chk("t6_awvalid_pre_reset", awvalid, 1);
    aresetn = 0;
    @(negedge clk);
    chk("t6_reset_valids", {30'd0, awvalid, wvalid}, 0);
    chk("t6_reset_busy", busy, 0);
    chk("t6_reset_done", done, 0);
    aresetn = 1;
    configure(0, 0, -1, -1, -1, 0);
    fork
      run("t6");
      begin
        repeat (5) @(negedge clk);
        chk("t6_busy_at_restart", busy, 1);
        start = 1;
        @(negedge clk) start = 0;
      end
    join
    repeat (20) @(negedge clk);
    chk("t6_status", status, 32'h0000_0001);
    chk("t6_restart_addr", aw_log[0], 32'h100);
    check_counts("t6", 4, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
